csla_pipe_addsub: RTL and testbench

//  Parametrised, pipelined carry-select adder/subtractor; successor to the fixed 16-bit CSLA.

---
 rtl/csla_pipe_addsub.sv | 138 +++++++++++++
 tb/tb_csla_pipe_addsub.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/csla_pipe_addsub.sv
// Pipelined carry-select adder/subtractor.
// The operands are split into NBLK segments of BLK bits. Segment 0 ripples from the
// prepared carry-in. Every other segment computes both possible sums and lets the
// incoming carry select one of them. STAGES register stages each cover NBLK/STAGES
// segments. A single advance signal stalls or moves the whole pipeline.
module csla_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLK;
    localparam int SPS  = NBLK / STAGES;   // segments handled per stage
    localparam int LAST = STAGES - 1;

    // Stage registers: valid, operands carried forward, partial sum, carry into next stage
    logic [STAGES-1:0]            r_v;
    logic [STAGES-1:0]            r_c;
    logic [STAGES-1:0][WIDTH-1:0] r_a;
    logic [STAGES-1:0][WIDTH-1:0] r_bx;
    logic [STAGES-1:0][WIDTH-1:0] r_s;
    logic                         r_ovf;

    // Per-stage combinational inputs and results
    logic [STAGES-1:0][WIDTH-1:0] w_a_in;
    logic [STAGES-1:0][WIDTH-1:0] w_bx_in;
    logic [STAGES-1:0][WIDTH-1:0] w_s_in;
    logic [STAGES-1:0][WIDTH-1:0] w_s_out;
    logic [STAGES-1:0]            w_v_in;
    logic [STAGES-1:0]            w_c_in;
    logic [STAGES-1:0]            w_c_out;
    logic [BLK:0]                 w_lo;
    logic [BLK:0]                 w_hi;
    logic [BLK:0]                 w_res;
    logic                         w_carry;
    logic                         w_ovf;
    logic                         w_adv;
    logic                         w_unused;

    // The pipeline moves whenever the output slot is empty or is being consumed
    assign w_adv    = ~r_v[LAST] | out_ready;
    assign in_ready = w_adv;

    // Per-stage segment arithmetic: feed each stage, then run its carry-select chain
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch can be inferred.
        w_a_in  = '0;
        w_bx_in = '0;
        w_s_in  = '0;
        w_s_out = '0;
        w_v_in  = '0;
        w_c_in  = '0;
        w_c_out = '0;
        w_lo    = '0;
        w_hi    = '0;
        w_res   = '0;
        w_carry = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                // Subtraction becomes a + ~b + 1; a borrow-in cancels that +1
                w_a_in[k]  = a;
                w_bx_in[k] = b ^ {WIDTH{sub}};
                w_s_in[k]  = '0;
                w_c_in[k]  = cin ^ sub;
                w_v_in[k]  = in_valid;
            end else begin
                w_a_in[k]  = r_a[(k > 0) ? k - 1 : 0];
                w_bx_in[k] = r_bx[(k > 0) ? k - 1 : 0];
                w_s_in[k]  = r_s[(k > 0) ? k - 1 : 0];
                w_c_in[k]  = r_c[(k > 0) ? k - 1 : 0];
                w_v_in[k]  = r_v[(k > 0) ? k - 1 : 0];
            end
            w_s_out[k] = w_s_in[k];
            w_carry    = w_c_in[k];
            for (int j = 0; j < SPS; j++) begin
                w_lo = {1'b0, w_a_in[k][(k*SPS+j)*BLK +: BLK]}
                     + {1'b0, w_bx_in[k][(k*SPS+j)*BLK +: BLK]};
                w_hi = w_lo + (BLK+1)'(1);
                if (k == 0 && j == 0) begin
                    // Lowest segment ripples straight from the prepared carry-in
                    w_res = w_lo + (BLK+1)'(w_carry);
                end else begin
                    w_res = w_carry ? w_hi : w_lo;
                end
                w_s_out[k][(k*SPS+j)*BLK +: BLK] = w_res[BLK-1:0];
                w_carry = w_res[BLK];
            end
            w_c_out[k] = w_carry;
        end
        // Signed overflow: same-sign operands producing a result of the other sign
        w_ovf = (w_a_in[LAST][WIDTH-1] == w_bx_in[LAST][WIDTH-1])
             && (w_s_out[LAST][WIDTH-1] != w_a_in[LAST][WIDTH-1]);
    end

    // Stage registers: synchronous clear, load all stages on advance, otherwise hold
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every stage sample the previous stage's old value.
        if (!rst_n) begin
            // NOTE: datapath registers are cleared as well as valids, so sum/cout/ovf read 0 after reset.
            r_v   <= '0;
            r_c   <= '0;
            r_a   <= '0;
            r_bx  <= '0;
            r_s   <= '0;
            r_ovf <= 1'b0;
        end else if (w_adv) begin
            r_v   <= w_v_in;
            r_c   <= w_c_out;
            r_a   <= w_a_in;
            r_bx  <= w_bx_in;
            r_s   <= w_s_out;
            r_ovf <= w_ovf;
        end
    end

    assign out_valid = r_v[LAST];
    assign sum       = r_s[LAST];
    assign cout      = r_c[LAST];
    assign ovf       = r_ovf;

    // The last stage's operand copies have no later stage to feed
    assign w_unused = ^{r_a[LAST], r_bx[LAST]};

endmodule

// File: tb/tb_csla_pipe_addsub.sv
// Self-checking bench for csla_pipe_addsub: directed corner cases, randomized
// handshake traffic against an arithmetic reference model, reset flush, and a
// parameter sweep over three further configurations.
module tb_csla_pipe_addsub;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default configuration DUT
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, sub, cout, ovf;

    csla_pipe_addsub #(.WIDTH(16), .BLK(4), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf));

    // Sweep DUTs share one stimulus bus, truncated to each width
    logic [63:0] sw_a, sw_b;
    logic        sw_cin, sw_sub, sw_valid;
    logic        sw_ordy = 1'b1;
    logic        r32, v32, c32, o32;
    logic [31:0] s32;
    logic        r1, v1, c1, o1;
    logic [15:0] s1;
    logic        r64, v64, c64, o64;
    logic [63:0] s64;

    csla_pipe_addsub #(.WIDTH(32), .BLK(8), .STAGES(4)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r32),
        .a(sw_a[31:0]), .b(sw_b[31:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v32),
        .out_ready(sw_ordy), .sum(s32), .cout(c32), .ovf(o32));

    csla_pipe_addsub #(.WIDTH(16), .BLK(4), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r1),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(v1),
        .out_ready(sw_ordy), .sum(s1), .cout(c1), .ovf(o1));

    csla_pipe_addsub #(.WIDTH(64), .BLK(4), .STAGES(16)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(r64),
        .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(v64),
        .out_ready(sw_ordy), .sum(s64), .cout(c64), .ovf(o64));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic on unsigned and signed interpretations.
    // Result packs {ovf, cout, sum} with sum in bits [w-1:0].
    function automatic logic [65:0] model(input int w, input logic [63:0] xa,
                                          input logic [63:0] xb, input logic xc, input logic xs);
        logic [67:0]        full, mask, ua, ub, ur, uc;
        logic signed [67:0] sa, sb, sr, sc, half;
        logic               co, ov;
        full = 68'd1 << w;
        mask = full - 68'd1;
        ua   = {4'd0, xa} & mask;
        ub   = {4'd0, xb} & mask;
        uc   = {67'd0, xc};
        sc   = $signed(uc);
        sa   = $signed(ua) - (ua[w-1] ? $signed(full) : 68'sd0);
        sb   = $signed(ub) - (ub[w-1] ? $signed(full) : 68'sd0);
        if (xs) begin
            ur = ua - ub - uc;
            co = (ua >= ub + uc);      // no borrow
            sr = sa - sb - sc;
        end else begin
            ur = ua + ub + uc;
            co = (ur >= full);
            sr = sa + sb + sc;
        end
        half = $signed(full >> 1);
        ov   = (sr >= half) || (sr < -half);
        return 66'((ur & mask) | ({67'd0, co} << w) | ({67'd0, ov} << (w + 1)));
    endfunction

    // One beat through the default DUT with out_ready held high
    task automatic run_beat(input logic [15:0] ta, input logic [15:0] tb_b, input logic tc,
                            input logic ts, output logic [17:0] got, output int lat);
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_b; cin = tc; sub = ts; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        got = {ovf, cout, sum};
    endtask

    // One beat into all sweep DUTs; records the edge count at which each result appears
    task automatic run_sweep(input logic [63:0] ta, input logic [63:0] tb_b,
                             input logic tc, input logic ts);
        int          l32, l1, l64;
        logic [65:0] g32, g1, g64;
        l32 = 0; l1 = 0; l64 = 0; g32 = '0; g1 = '0; g64 = '0;
        @(negedge clk);
        sw_a = ta; sw_b = tb_b; sw_cin = tc; sw_sub = ts; sw_valid = 1'b1;
        @(negedge clk);
        sw_valid = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            if (l32 == 0 && v32) begin l32 = e; g32 = 66'({o32, c32, s32}); end
            if (l1 == 0 && v1)   begin l1 = e;  g1 = 66'({o1, c1, s1}); end
            if (l64 == 0 && v64) begin l64 = e; g64 = {o64, c64, s64}; end
            if (l32 != 0 && l1 != 0 && l64 != 0) break;
            @(negedge clk);
        end
        check("sw32_lat", 66'(l32), 66'd4);
        check("sw32_res", g32, model(32, ta, tb_b, tc, ts));
        check("sw1_lat", 66'(l1), 66'd1);
        check("sw1_res", g1, model(16, ta, tb_b, tc, ts));
        check("sw64_lat", 66'(l64), 66'd16);
        check("sw64_res", g64, model(64, ta, tb_b, tc, ts));
    endtask

    // Directed corner cases with hand-computed {ovf, cout, sum}
    logic [15:0] d_a   [6] = '{16'hFFFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000, 16'h0010};
    logic [15:0] d_b   [6] = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0007, 16'h0001, 16'h0003};
    logic        d_cin [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        d_sub [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [17:0] d_exp [6] = '{18'h1_0000, 18'h2_8000, 18'h3_7FFF, 18'h0_FFFE, 18'h3_7FFF, 18'h1_000C};

    // Hard time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // Main stimulus sequence
    initial begin
        logic [17:0] got, exp, held;
        logic [65:0] m;
        logic [17:0] q[$];
        int          lat, sent, cyc;
        logic        hold, stale;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", 66'({out_valid, ovf, cout, sum}), 66'd0);
        check("rst_in_ready", 66'(in_ready), 66'd1);
        check("rst_sweep_ready", 66'({r32, r1, r64}), 66'h7);
        rst_n = 1'b1;

        // Directed corner cases
        for (int i = 0; i < 6; i++) begin
            run_beat(d_a[i], d_b[i], d_cin[i], d_sub[i], got, lat);
            check($sformatf("dir%0d_lat", i), 66'(lat), 66'd2);
            check($sformatf("dir%0d_res", i), 66'(got), 66'(d_exp[i]));
        end

        // Randomized traffic with random valid and backpressure
        sent = 0; cyc = 0; hold = 1'b0; held = '0;
        while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (hold) check("stall_hold", 66'({out_valid, ovf, cout, sum}), 66'({1'b1, held}));
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            a   = 16'($urandom);
            b   = 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            #1;
            check("in_ready", 66'(in_ready), 66'(!out_valid | out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("extra_beat", 66'd1, 66'd0);
                end else begin
                    exp = q.pop_front();
                    check("rand_res", 66'({ovf, cout, sum}), 66'(exp));
                end
            end
            if (in_valid && in_ready) begin
                m = model(16, {48'd0, a}, {48'd0, b}, cin, sub);
                q.push_back(m[17:0]);
                sent++;
            end
            hold = out_valid && !out_ready;
            held = {ovf, cout, sum};
        end
        check("rand_drained", 66'((sent == 1000) && (q.size() == 0)), 66'd1);

        // Reset with beats in flight; a beat offered during the reset cycle must also vanish
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0001;
        @(negedge clk);
        rst_n = 1'b0; a = 16'h0F0F; b = 16'h0101;
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        check("flush_state", 66'({out_valid, ovf, cout, sum}), 66'd0);
        check("flush_in_ready", 66'(in_ready), 66'd1);
        stale = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("flush_no_stale", 66'(stale), 66'd0);

        // Parameter sweep: carry chains ending at assorted segment boundaries
        foreach (d_a[i]) begin end
        for (int n = 4; n <= 64; n += 6) begin
            run_sweep((n == 64) ? '1 : ((64'd1 << n) - 64'd1), 64'd1, 1'b0, 1'b0);
            run_sweep((n == 64) ? 64'h8000_0000_0000_0000 : (64'd1 << n), 64'd1, 1'b0, 1'b1);
        end
        run_sweep('1, 64'd0, 1'b1, 1'b0);
        run_sweep(64'h7FFF_FFFF_7FFF_7FFF, 64'd1, 1'b0, 1'b0);
        run_sweep(64'h0, 64'h0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
